// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared single-port memory: fetch (I) and load/store (D) ports.
// D wins collisions unless I has been passed over STARVE_MAX times in a row.
module mem_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  starve_cnt, starve_nxt;
    logic              mem_req_nxt, mem_we_nxt, i_done_nxt, d_done_nxt;
    logic [DATA_W-1:0] mem_addr_nxt, mem_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
    logic              i_elig, d_elig, starved;

    assign stall_if  = i_req & ~i_done;
    assign stall_mem = d_req & ~d_done;

    // A requester whose done is still high this cycle is not re-granted yet.
    assign i_elig  = i_req & ~i_done;
    assign d_elig  = d_req & ~d_done;
    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        state_nxt     = state;
        starve_nxt    = starve_cnt;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        i_done_nxt    = 1'b0;
        d_done_nxt    = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;
        case (state)
            IDLE: begin
                if (i_elig && (!d_elig || starved)) begin
                    state_nxt     = BUSY_I;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = i_addr;
                    mem_wdata_nxt = '0;
                    starve_nxt    = '0;
                end else if (d_elig) begin
                    state_nxt     = BUSY_D;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                    // Saturating count of D grants taken while a fetch is pending.
                    if (!i_req) begin
                        starve_nxt = '0;
                    end else if (!starved) begin
                        starve_nxt = starve_cnt + CNT_W'(1);
                    end
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    i_done_nxt  = 1'b1;
                    i_rdata_nxt = mem_rdata;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    d_done_nxt  = 1'b1;
                    if (!mem_we) begin
                        d_rdata_nxt = mem_rdata;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            i_done     <= i_done_nxt;
            d_done     <= d_done_nxt;
            i_rdata    <= i_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
        end
    end

endmodule
